i2s_tx_master: RTL

I2S bus master and transmit sequencer, clocked from the system clock. Divides clk down to generate bck and lrck and serialises stereo samples onto dout in standard I2S framing. Samples are buffered through a one-deep holding register with a valid/ready handshake. This block drives the timing that i2s_rx-style receivers consume, so it can also feed loopback tests.

---
 rtl/i2s_tx_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/i2s_tx_master.sv
// I2S transmit master: divides clk into bck/lrck and serialises buffered stereo pairs.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN: on underrun, resend the previous pair instead of zeros.
module i2s_tx_master #(
    parameter int WORD_SIZE = 24,
    parameter int SLOT_BITS = 32,
    parameter int BCK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WORD_SIZE-1:0] l_din,
    input  logic [WORD_SIZE-1:0] r_din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 underrun_clr,
    output logic                 bck,
    output logic                 lrck,
    output logic                 dout,
    output logic                 frame_start,
    output logic                 underrun
);

    localparam int FRAME = 2 * SLOT_BITS;
    localparam int KW    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int DW    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(FRAME - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

    logic [DW-1:0]        div_cnt;
    logic [KW-1:0]        k;
    logic [KW-1:0]        k_next;
    logic                 hold_full;
    logic [WORD_SIZE-1:0] hold_l;
    logic [WORD_SIZE-1:0] hold_r;
    logic [WORD_SIZE-1:0] sh_l;
    logic [WORD_SIZE-1:0] sh_r;
    logic [WORD_SIZE-1:0] load_l;
    logic [WORD_SIZE-1:0] load_r;
    logic                 tick;
    logic                 fall;
    logic                 load;
    logic                 accept;
    logic                 lrck_next;
    logic                 dout_next;
    logic                 bit_l;
    logic                 bit_r;
    int                   kn;

    assign din_ready = !hold_full;

    always_comb begin
        tick   = en && (div_cnt == DIV_LAST);
        fall   = tick && bck;
        k_next = (k == K_LAST) ? '0 : k + KW'(1);
        load   = fall && (k_next == '0);
        accept = din_valid && !hold_full;
        kn     = int'(k_next);

        if (hold_full) begin
            load_l = hold_l;
            load_r = hold_r;
        end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            load_l = sh_l;
            load_r = sh_r;
`else
            load_l = '0;
            load_r = '0;
`endif
        end

        // Bit k of the frame: left word MSB-first from k=0, right word from k=SLOT_BITS.
        bit_l = 1'b0;
        bit_r = 1'b0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (kn == WORD_SIZE - 1 - i)
                bit_l = sh_l[i];
            if (kn == SLOT_BITS + WORD_SIZE - 1 - i)
                bit_r = sh_r[i];
        end

        lrck_next = (kn >= SLOT_BITS - 1) && (kn <= 2 * SLOT_BITS - 2);
        dout_next = load ? load_l[WORD_SIZE-1] : (bit_l | bit_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            bck         <= 1'b0;
            lrck        <= 1'b0;
            dout        <= 1'b0;
            k           <= K_LAST;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
        end else begin
            frame_start <= load;

            if (!en) begin
                div_cnt <= '0;
                bck     <= 1'b0;
                lrck    <= 1'b0;
                dout    <= 1'b0;
                k       <= K_LAST;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                if (tick)
                    bck <= !bck;
                if (fall) begin
                    k    <= k_next;
                    lrck <= lrck_next;
                    dout <= dout_next;
                end
            end

            if (load) begin
                sh_l <= load_l;
                sh_r <= load_r;
            end

            // A pair offered during an empty-buffer load still lands for the next frame.
            if (accept) begin
                hold_l    <= l_din;
                hold_r    <= r_din;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load && !hold_full)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule
